// File: rtl/fifo_write_arbiter_pkg.sv
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and width helpers for the FIFO write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int burst_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_write_arbiter_if.sv
// ============================================================================
// Module      : fifo_write_arbiter_if
// Description : Requester and FIFO write-port bundle for fifo_write_arbiter.
//               stat_count exists only when FIFO_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_write_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);

  localparam int c_IDX_W = idx_width(NUM_REQ);

  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         data_in;
  logic                          data_in_valid;
  logic                          data_in_full;
  logic [c_IDX_W-1:0]            grant_id;
  logic                          grant_active;
`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]         stat_count;

  modport master (
    input  req_data, req_valid, data_in_full,
    output req_ready, data_in, data_in_valid, grant_id, grant_active, stat_count
  );

  modport slave (
    output req_data, req_valid, data_in_full,
    input  req_ready, data_in, data_in_valid, grant_id, grant_active, stat_count
  );
`else
  modport master (
    input  req_data, req_valid, data_in_full,
    output req_ready, data_in, data_in_valid, grant_id, grant_active
  );

  modport slave (
    output req_data, req_valid, data_in_full,
    input  req_ready, data_in, data_in_valid, grant_id, grant_active
  );
`endif

endinterface

`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_select.sv
// ============================================================================
// Module      : rr_select
// Description : Combinational round-robin pick: first set request after
//               i_last_grant, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_select
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] i_req,
  input  wire logic [IDX_W-1:0]   i_last_grant,
  output logic      [IDX_W-1:0]   o_sel,
  output logic                    o_any_req
);

  always_comb begin
    o_sel     = '0;
    o_any_req = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!o_any_req && i_req[(int'(i_last_grant) + k) % NUM_REQ]) begin
        o_any_req = 1'b1;
        o_sel     = IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin burst arbiter sharing one FIFO write port among
//               NUM_REQ producers. Optional per-requester transfer counters
//               are enabled with the FIFO_ARB_STATS_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  wire logic            clock_in,
  input  wire logic            rst_in_n,
  fifo_write_arbiter_if.master bus
);

  localparam int               c_IDX_W     = idx_width(NUM_REQ);
  localparam int               c_CNT_W     = burst_cnt_width(MAX_BURST);
  localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(MAX_BURST - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_INIT = c_IDX_W'(NUM_REQ - 1);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [c_IDX_W-1:0] r_grant_id;
  logic [c_IDX_W-1:0] w_grant_id_nxt;
  logic [c_IDX_W-1:0] r_last_grant;
  logic [c_IDX_W-1:0] w_last_grant_nxt;
  logic [c_CNT_W-1:0] r_burst_cnt;
  logic [c_CNT_W-1:0] w_burst_cnt_nxt;

  logic [c_IDX_W-1:0] w_sel;
  logic               w_any_req;
  logic               w_gnt_valid;
  logic               w_grant_active;
  logic               w_data_in_valid;
  logic               w_xfer;
  logic [NUM_REQ-1:0] w_req_ready;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_IDX_W)
  ) u_rr_select (
    .i_req        (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_sel        (w_sel),
    .o_any_req    (w_any_req)
  );

  assign w_gnt_valid = bus.req_valid[r_grant_id];
  assign w_xfer      = w_data_in_valid && !bus.data_in_full;

  always_ff @(posedge clock_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_grant_id   <= '0;
      r_last_grant <= c_LAST_INIT;
      r_burst_cnt  <= '0;
    end else begin
      r_grant_id   <= w_grant_id_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
    end
  end

  // A dropped valid ends the grant even while the FIFO is full.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_id_nxt   = r_grant_id;
    w_last_grant_nxt = r_last_grant;
    w_burst_cnt_nxt  = r_burst_cnt;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt     = GRANT;
          w_grant_id_nxt  = w_sel;
          w_burst_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (!w_gnt_valid) begin
          w_state_nxt      = IDLE;
          w_last_grant_nxt = r_grant_id;
        end else if (w_xfer) begin
          if (r_burst_cnt == c_LAST_BEAT) begin
            w_state_nxt      = IDLE;
            w_last_grant_nxt = r_grant_id;
          end else begin
            w_burst_cnt_nxt = r_burst_cnt + c_CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_grant_active  = (r_state == GRANT);
    w_data_in_valid = w_grant_active && w_gnt_valid;
    w_req_ready     = '0;
    if (w_grant_active && !bus.data_in_full) begin
      w_req_ready[r_grant_id] = 1'b1;
    end
  end

  assign bus.grant_active  = w_grant_active;
  assign bus.grant_id      = r_grant_id;
  assign bus.data_in_valid = w_data_in_valid;
  assign bus.req_ready     = w_req_ready;
  assign bus.data_in       = bus.req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];

`ifdef FIFO_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    logic [15:0] r_count;

    // Saturating so a long-running requester never wraps back to a small value.
    always_ff @(posedge clock_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
        r_count <= '0;
      end else if (w_xfer && (r_grant_id == c_IDX_W'(gi)) && (r_count != 16'hFFFF)) begin
        r_count <= r_count + 16'd1;
      end
    end

    assign bus.stat_count[gi*16 +: 16] = r_count;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Directed and random stimulus for fifo_write_arbiter checked
//               against a per-cycle behavioural model of the grant rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_write_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 32;
  localparam int MAX_BURST  = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_write_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clock_in (clk),
    .rst_in_n (rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: owner = -1 means no grant (idle bubble)
  int m_owner, m_gid, m_last, m_done;
  int seq      [NUM_REQ];
  int stat_exp [NUM_REQ];
  int grant_log[$];
  logic prev_active;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] word_of(input int i);
    return {8'(i), 24'(seq[i])};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_gid   = 0;
    m_last  = NUM_REQ - 1;
    m_done  = 0;
  endtask

  task automatic run_cycle(input logic [NUM_REQ-1:0] v, input logic full);
    logic             exp_act;
    logic             exp_take;
    logic [NUM_REQ-1:0] exp_rdy;
    bit               found;
    int               c;
    @(negedge clk);
    bus.req_valid    = v;
    bus.data_in_full = full;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = word_of(i);
    #1;
    exp_act  = rst_n && (m_owner >= 0);
    exp_take = exp_act ? v[m_owner] : 1'b0;
    exp_rdy  = '0;
    if (exp_act && !full) exp_rdy[m_owner] = 1'b1;
    check("grant_active", 64'(bus.grant_active), 64'(exp_act));
    check("grant_id", 64'(bus.grant_id), 64'(m_gid));
    check("data_in", 64'(bus.data_in), 64'(word_of(m_gid)));
    check("data_in_valid", 64'(bus.data_in_valid), 64'(exp_take));
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    if (bus.grant_active && !prev_active) grant_log.push_back(int'(bus.grant_id));
    prev_active = bus.grant_active;
    for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i] && v[i]) seq[i]++;
    if (rst_n) begin
      if (m_owner < 0) begin
        found = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          c = (m_last + k) % NUM_REQ;
          if (!found && v[c]) begin
            found   = 1;
            m_owner = c;
            m_gid   = c;
            m_done  = 0;
          end
        end
      end else if (!v[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (!full) begin
        m_done++;
        if (stat_exp[m_owner] < 16'hFFFF) stat_exp[m_owner]++;
        if (m_done == MAX_BURST) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_data_in_valid", 64'(bus.data_in_valid), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_grant_active", 64'(bus.grant_active), 64'd0);
    model_reset();
    prev_active = 1'b0;
    run_cycle('1, 1'b0);
    run_cycle('1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int cycles, stall, b1, b3;
    for (int i = 0; i < NUM_REQ; i++) begin
      seq[i]      = 0;
      stat_exp[i] = 0;
    end
    prev_active      = 1'b0;
    bus.req_valid    = '0;
    bus.req_data     = '0;
    bus.data_in_full = 1'b0;
    rst_n            = 1'b0;
    model_reset();
    #1;
    check("reset_grant_active", 64'(bus.grant_active), 64'd0);
    check("reset_grant_id", 64'(bus.grant_id), 64'd0);
    run_cycle('0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Single requester, 20 words: bursts 8/8/4 with one bubble each
    cycles = 0;
    while (seq[2] < 20 && cycles < 100) begin
      run_cycle((seq[2] < 20) ? 4'b0100 : 4'b0000, 1'b0);
      cycles++;
    end
    check("single_words", 64'(seq[2]), 64'd20);
    check("single_cycles", 64'(cycles), 64'd23);
    run_cycle('0, 1'b0);
    run_cycle('0, 1'b0);

    // All requesters valid: rotation 0,1,2,3,0
    apply_reset();
    grant_log.delete();
    for (int n = 0; n < 45; n++) run_cycle('1, 1'b0);
    check("rr_grants_seen", 64'(grant_log.size() >= 5), 64'd1);
    if (grant_log.size() >= 5) begin
      check("rr_grant0", 64'(grant_log[0]), 64'd0);
      check("rr_grant1", 64'(grant_log[1]), 64'd1);
      check("rr_grant2", 64'(grant_log[2]), 64'd2);
      check("rr_grant3", 64'(grant_log[3]), 64'd3);
      check("rr_grant4", 64'(grant_log[4]), 64'd0);
    end

    // Full stall for 5 cycles after 3 words of a burst
    apply_reset();
    b1 = seq[0];
    stall = 0;
    cycles = 0;
    while (seq[0] - b1 < 8 && cycles < 60) begin
      if (seq[0] - b1 == 3 && stall < 5) begin
        run_cycle(4'b0001, 1'b1);
        stall++;
      end else begin
        run_cycle(4'b0001, 1'b0);
      end
      cycles++;
    end
    check("stall_burst_words", 64'(seq[0] - b1), 64'd8);
    check("stall_cycles", 64'(cycles), 64'd14);

    // Requester 1 drops after 2 words; pending requester 3 goes next
    apply_reset();
    b1 = seq[1];
    b3 = seq[3];
    cycles = 0;
    while (seq[3] == b3 && cycles < 40) begin
      run_cycle({1'b1, 1'b0, (seq[1] - b1 < 2), 1'b0}, 1'b0);
      cycles++;
    end
    check("drop_r1_words", 64'(seq[1] - b1), 64'd2);
    check("drop_r3_next", 64'(seq[3] - b3), 64'd1);
    check("drop_cycles", 64'(cycles), 64'd6);

    // Random traffic with occasional back-pressure and resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) apply_reset();
      run_cycle(NUM_REQ'($urandom) | NUM_REQ'($urandom), ($urandom_range(0, 4) == 0));
    end

`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      check("stat_count", 64'(bus.stat_count[i*16 +: 16]), 64'(stat_exp[i]));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the write port of one FIFO instance among NUM_REQ producers in the FIFO's write clock domain.
- Grants one requester at a time for a burst of up to MAX_BURST words, then re-arbitrates.
- Drives the FIFO's data_in / data_in_valid and obeys its data_in_full back-pressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, word width; must match the FIFO.
- MAX_BURST, 8, max words transferred per grant (1..256).

Ports:
- clock_in  input  1  write-domain clock (FIFO clock_in).
- rst_in_n  input  1  asynchronous active-low reset (FIFO rst_in_n).
- req_data  input  NUM_REQ*DATA_WIDTH  requester words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_valid  input  NUM_REQ  requester i has a word.
- req_ready  output  NUM_REQ  word of requester i is accepted this cycle.
- data_in  output  DATA_WIDTH  to FIFO data_in.
- data_in_valid  output  1  to FIFO data_in_valid.
- data_in_full  input  1  from FIFO data_in_full.
- grant_id  output  max(1,$clog2(NUM_REQ))  currently granted requester.
- grant_active  output  1  high while in GRANT state.

Behaviour:
- Interface: one clock, clock_in; reset rst_in_n, asynchronous, active-low.
- Transfer definition: a word moves when data_in_valid && !data_in_full. It moves at the same clock edge as req_ready[grant_id] && req_valid[grant_id].
- Registered state (async reset values):
  - state = IDLE
  - grant_id = 0
  - last_grant = NUM_REQ-1, so requester 0 wins first
  - burst_cnt = 0
- Combinational outputs:
  - grant_active = (state==GRANT).
  - data_in = req_data slice for grant_id.
  - data_in_valid = grant_active && req_valid[grant_id].
  - req_ready[i] = grant_active && grant_id==i && !data_in_full.
  - During and after reset: data_in_valid = 0, req_ready = 0, grant_active = 0.
- State IDLE:
  - If any req_valid: select the first set bit searching last_grant+1, last_grant+2, … modulo NUM_REQ.
  - Next cycle: state=GRANT, grant_id=selected, burst_cnt=0.
  - Arbitration latency: 1 cycle from req_valid to data_in_valid.
- State GRANT:
  - On each transfer, burst_cnt increments.
  - Transfer with burst_cnt==MAX_BURST-1: go to IDLE, last_grant=grant_id.
  - req_valid[grant_id]==0 at a clock edge: go to IDLE, last_grant=grant_id. No word is transferred that cycle.
  - data_in_full high: hold grant and burst_cnt. No timeout; the FIFO drains.
- Every re-arbitration costs exactly one IDLE bubble cycle.
- Fairness: a requester that is continuously valid waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles plus full-stall cycles.
- Simultaneous requests in IDLE: round-robin order decides. Non-granted requesters' req_valid is ignored and must be held by the requester.
- Changes to req_valid of non-granted requesters in GRANT have no effect until the next IDLE.
- Reset mid-burst: immediate return to reset values. A word presented in the reset cycle is not transferred.
- MAX_BURST=1: GRANT lasts exactly one transfer.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- When defined:
  - Adds output stat_count, NUM_REQ*16 bits.
  - One 16-bit counter per requester, incremented on each of its transfers.
  - Counters saturate at 16'hFFFF and reset to 0 on rst_in_n.
- When undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, GRANT}.
  - Function for index width: max(1,$clog2(n)).
  - Burst counter width constant: $clog2(MAX_BURST+1).
- Sub-module rr_select:
  - Combinational; inputs request vector and last_grant; outputs selected index and any_req.
  - Instantiated once.

Test Plan:
- Single requester, NUM_REQ=4, MAX_BURST=8, req_valid[2] held high with 20 words, full=0:
  - expect bursts of 8, 8, 4 words on data_in in order;
  - one IDLE cycle between bursts; grant_id=2 throughout.
- All four requesters continuously valid:
  - grant sequence is 0,1,2,3,0;
  - each burst is exactly 8 transfers; no data from non-granted requesters appears.
- data_in_full asserted for 5 cycles mid-burst after 3 words:
  - req_ready stays 0 and data_in holds the 4th word;
  - burst resumes with 5 more words before release.
- Requester 1 drops req_valid after 2 words:
  - return to IDLE next cycle;
  - requester 3, pending, is granted next rather than 1 re-granted.
- Assert rst_in_n low asynchronously mid-burst:
  - data_in_valid, req_ready and grant_active go to 0 immediately;
  - after release, requester 0 is granted first.
- With FIFO_ARB_STATS_EN: force 70000 transfers from requester 0 → stat_count[15:0]=16'hFFFF; other counters match their transfer counts.
